// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmit serializer, one stereo pair per lrclk frame, MSB first.
// Codec-mastered bclk/lrclk; a single holding register decouples the upstream handshake from the frame timing.
module i2s_tx_serializer #(
  parameter int I2S_WIDTH        = 24,
  parameter int AUDIO_WIDTH      = 24,
  parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
  input  logic                   i2s_bclk,
  input  logic                   sys_rst,
  input  logic                   i2s_lrclk,
  input  logic [AUDIO_WIDTH-1:0] tx_left,
  input  logic [AUDIO_WIDTH-1:0] tx_right,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   i2s_dout,
  output logic                   frame_start,
  output logic                   underrun,
  output logic [15:0]            underrun_count,
  output logic                   slot_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  localparam logic [5:0]  CNT_MAX  = 6'd63;
  localparam logic [5:0]  MIN_CNT  = 6'(I2S_WIDTH - 1);
  localparam logic [15:0] URC_MAX  = 16'hFFFF;

  logic [1:0]             state_q, state_d;
  logic                   prev_lrclk_q;
  logic                   hold_full_q, hold_full_d;
  logic [AUDIO_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [AUDIO_WIDTH-1:0] hold_right_q, hold_right_d;
  logic [AUDIO_WIDTH-1:0] act_left_q, act_left_d;
  logic [AUDIO_WIDTH-1:0] act_right_q, act_right_d;
  logic [I2S_WIDTH-1:0]   shreg_q, shreg_d;
  logic [5:0]             bit_cnt_q, bit_cnt_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;
  logic [15:0]            urc_q, urc_d;
  logic                   slot_err_q, slot_err_d;

  logic                   left_edge, right_edge, any_edge;
  logic                   accept, take_hold;
  logic                   load_left, load_right;
  logic [I2S_WIDTH-1:0]   left_word, right_word;

  assign left_edge  = prev_lrclk_q & ~i2s_lrclk;
  assign right_edge = ~prev_lrclk_q & i2s_lrclk;
  assign any_edge   = left_edge | right_edge;
  assign accept     = tx_valid & ~hold_full_q;

  // Samples are MSB-aligned into the slot: wider samples lose LSBs, narrower ones are zero-padded.
  if (AUDIO_WIDTH >= I2S_WIDTH) begin : g_trunc
    assign left_word  = act_left_d[AUDIO_WIDTH-1 -: I2S_WIDTH];
    assign right_word = act_right_d[AUDIO_WIDTH-1 -: I2S_WIDTH];
  end else begin : g_pad
    assign left_word  = {act_left_d, {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
    assign right_word = {act_right_d, {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
  end

  always_comb begin
    state_d       = state_q;
    hold_full_d   = hold_full_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    act_left_d    = act_left_q;
    act_right_d   = act_right_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    urc_d         = urc_q;
    slot_err_d    = slot_err_q;
    take_hold     = 1'b0;
    load_left     = 1'b0;
    load_right    = 1'b0;
    bit_cnt_d     = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 6'd1;

    if (accept) begin
      hold_left_d  = tx_left;
      hold_right_d = tx_right;
      hold_full_d  = 1'b1;
    end

    if (any_edge) begin
      bit_cnt_d = 6'd0;
      if (state_q != ST_IDLE && bit_cnt_q < MIN_CNT) begin
        slot_err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (left_edge && hold_full_q) begin
          take_hold = 1'b1;
        end
      end
      ST_LEFT: begin
        if (right_edge) begin
          load_right = 1'b1;
          state_d    = ST_RIGHT;
        end
      end
      ST_RIGHT: begin
        if (left_edge) begin
          if (hold_full_q) begin
            take_hold = 1'b1;
          end else begin
            underrun_d = 1'b1;
            urc_d      = (urc_q == URC_MAX) ? urc_q : urc_q + 16'd1;
            if (MUTE_ON_UNDERRUN) begin
              act_left_d  = '0;
              act_right_d = '0;
            end
            load_left = 1'b1;
            state_d   = ST_LEFT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // accept requires an empty hold, so it never coincides with consuming the hold here.
    if (take_hold) begin
      act_left_d    = hold_left_q;
      act_right_d   = hold_right_q;
      hold_full_d   = 1'b0;
      frame_start_d = 1'b1;
      load_left     = 1'b1;
      state_d       = ST_LEFT;
    end
  end

  always_comb begin
    shreg_d = {shreg_q[I2S_WIDTH-2:0], 1'b0};
    if (any_edge) begin
      if (load_left) begin
        shreg_d = left_word;
      end else if (load_right) begin
        shreg_d = right_word;
      end else begin
        shreg_d = '0;
      end
    end
  end

  always_ff @(posedge i2s_bclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      prev_lrclk_q  <= 1'b1;
      hold_full_q   <= 1'b0;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      act_left_q    <= '0;
      act_right_q   <= '0;
      shreg_q       <= '0;
      bit_cnt_q     <= 6'd0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      urc_q         <= 16'd0;
      slot_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_lrclk_q  <= i2s_lrclk;
      hold_full_q   <= hold_full_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      act_left_q    <= act_left_d;
      act_right_q   <= act_right_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      urc_q         <= urc_d;
      slot_err_q    <= slot_err_d;
    end
  end

  assign tx_ready       = ~hold_full_q;
  assign i2s_dout       = shreg_q[I2S_WIDTH-1];
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = urc_q;
  assign slot_err       = slot_err_q;

endmodule
